// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester channels and the single memory port served by mem_port_arbiter.
// Request handshake: a transfer happens in the cycle where valid && ready; the requester holds its
// address/data steady until then; responses are single-cycle pulses with no back-pressure.
interface mem_port_arbiter_if;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_resp_valid;
  logic [31:0] inst_resp_data;

  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_req_addr;
  logic        data_req_write;
  logic [31:0] data_req_wdata;
  logic [3:0]  data_req_wstrb;
  logic        data_resp_valid;
  logic [31:0] data_resp_data;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  inst_req_valid, inst_req_addr,
    input  data_req_valid, data_req_addr, data_req_write, data_req_wdata, data_req_wstrb,
    input  mem_rdata,
    output inst_req_ready, inst_resp_valid, inst_resp_data,
    output data_req_ready, data_resp_valid, data_resp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output inst_req_valid, inst_req_addr,
    output data_req_valid, data_req_addr, data_req_write, data_req_wdata, data_req_wstrb,
    output mem_rdata,
    input  inst_req_ready, inst_resp_valid, inst_resp_data,
    input  data_req_ready, data_resp_valid, data_resp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one synchronous memory port,
// data-first with a bounded number of consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              dbg_state
);

  localparam int CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    lat_cnt, lat_cnt_next;
  logic                resp_due, resp_due_next;
  logic                owner_data;
  logic                owner_store;
  logic [STARVE_W-1:0] starve_cnt;
  logic [31:0]         inst_hold;
  logic [31:0]         data_hold;

  logic grant_data;
  logic grant_inst;
  logic handshake;

  // Address bits [1:0] are intentionally ignored: accesses are word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.inst_req_addr[1:0], bus.data_req_addr[1:0]};

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state == IDLE) begin
      if (bus.data_req_valid && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
        grant_data = 1'b1;
      end else if (bus.inst_req_valid) begin
        grant_inst = 1'b1;
      end else if (bus.data_req_valid) begin
        grant_data = 1'b1;
      end
    end
  end

  assign handshake          = grant_data | grant_inst;
  assign bus.data_req_ready = grant_data;
  assign bus.inst_req_ready = grant_inst;

  always_comb begin
    bus.mem_en    = handshake;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (grant_data) begin
      bus.mem_addr  = {bus.data_req_addr[31:2], 2'b00};
      bus.mem_wdata = bus.data_req_wdata;
      if (bus.data_req_write) begin
        bus.mem_we = bus.data_req_wstrb;
      end
    end else if (grant_inst) begin
      bus.mem_addr = {bus.inst_req_addr[31:2], 2'b00};
    end
  end

  // The response cycle is spent in IDLE, so a new access can be accepted alongside it.
  always_comb begin
    state_next    = state;
    lat_cnt_next  = lat_cnt;
    resp_due_next = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (READ_LATENCY == 1) begin
            resp_due_next = 1'b1;
          end else begin
            state_next   = WAIT;
            lat_cnt_next = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (lat_cnt == CNT_W'(READ_LATENCY - 1)) begin
          state_next    = IDLE;
          lat_cnt_next  = '0;
          resp_due_next = 1'b1;
        end else begin
          lat_cnt_next = lat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        lat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      resp_due <= 1'b0;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_cnt_next;
      resp_due <= resp_due_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_data  <= 1'b0;
      owner_store <= 1'b0;
      starve_cnt  <= '0;
    end else if (handshake) begin
      owner_data  <= grant_data;
      owner_store <= grant_data & bus.data_req_write;
      if (grant_data && bus.inst_req_valid) begin
        if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign bus.inst_resp_valid = resp_due & ~owner_data;
  assign bus.data_resp_valid = resp_due & owner_data;

  // Read data is passed straight through in the response cycle and held afterwards.
  assign bus.inst_resp_data = bus.inst_resp_valid ? bus.mem_rdata : inst_hold;
  assign bus.data_resp_data = bus.data_resp_valid ? (owner_store ? 32'h0 : bus.mem_rdata)
                                                  : data_hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_hold <= 32'h0;
      data_hold <= 32'h0;
    end else begin
      if (bus.inst_resp_valid) begin
        inst_hold <= bus.mem_rdata;
      end
      if (bus.data_resp_valid) begin
        data_hold <= owner_store ? 32'h0 : bus.mem_rdata;
      end
    end
  end

  assign bus.busy  = (state == WAIT);
  assign dbg_state = state;

  a_one_ready : assert property (@(posedge clock) disable iff (!reset)
    !(bus.inst_req_ready && bus.data_req_ready));
  a_one_resp : assert property (@(posedge clock) disable iff (!reset)
    !(bus.inst_resp_valid && bus.data_resp_valid));

endmodule
